mac_accumulator: RTL and testbench

Signed fixed-point multiply-accumulate stage that sits directly upstream of the team's signed enable/clear output register. It accepts a stream of sample/coefficient pairs under a valid/ready handshake and accumulates their products over a frame delimited by s_last. At frame end it rounds, shifts and saturates the sum to WIDTH bits. It presents the result on m_data/m_valid, ready to drive the register's d and en inputs.

---
 rtl/mac_accumulator_pkg.sv | 16 +
 rtl/mac_accumulator_round_sat.sv | 29 ++
 rtl/mac_accumulator.sv | 83 ++++++++
 tb/tb_mac_accumulator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accumulator_pkg.sv
// mac_pkg: shared state encoding, rounding and saturation helpers for mac_accumulator
package mac_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    function automatic longint round_const(input int frac);
        return frac > 0 ? longint'(1) <<< (frac - 1) : longint'(0);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction
endpackage

// File: rtl/mac_accumulator_round_sat.sv
// round_sat: round-half-up, arithmetic shift by FRAC and clamp to a signed WIDTH-bit result
module round_sat
    import mac_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int FRAC      = 15
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [WIDTH-1:0]     data,
    output logic                        ovf
);
    localparam logic signed [ACC_WIDTH:0] MAXV = (ACC_WIDTH + 1)'(sat_max(WIDTH));
    localparam logic signed [ACC_WIDTH:0] MINV = (ACC_WIDTH + 1)'(sat_min(WIDTH));
    localparam logic signed [ACC_WIDTH:0] RC   = (ACC_WIDTH + 1)'(round_const(FRAC));

    // one guard bit so the rounding constant cannot wrap a near-full accumulator
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] shifted;
    logic hi;
    logic lo;

    assign ext     = {acc[ACC_WIDTH-1], acc} + RC;
    assign shifted = ext >>> FRAC;
    assign hi      = shifted > MAXV;
    assign lo      = shifted < MINV;
    assign data    = hi ? MAXV[WIDTH-1:0] : lo ? MINV[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign ovf     = hi || lo;
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: two-stage signed multiply-accumulate over s_last-delimited frames with rounded, saturated output
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int FRAC      = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_a,
    input  logic signed [WIDTH-1:0] s_b,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_ovf
);
    logic signed [2*WIDTH-1:0]   p_reg;
    logic                        p_valid;
    logic                        p_last;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [WIDTH-1:0]     result;
    logic                        result_ovf;
    logic                        adv;
    logic                        accept;
    state_t                      state;

    // state is a decode of the pipeline registers; HOLD freezes both stages
    always_comb begin
        state    = (m_valid && !m_ready) ? HOLD : (p_valid || acc != '0) ? ACCUM : IDLE;
        adv      = (state != HOLD) && !clr;
        s_ready  = adv && !rst;
        accept   = s_valid && s_ready;
        acc_next = acc + ACC_WIDTH'(p_reg);
    end

    round_sat #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .FRAC(FRAC)) u_round_sat (
        .acc  (acc_next),
        .data (result),
        .ovf  (result_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg   <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            acc     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ovf   <= 1'b0;
        end else if (clr) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            acc     <= '0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (adv) begin
                p_reg   <= s_a * s_b;
                p_valid <= accept;
                p_last  <= s_last && accept;
                if (p_valid) begin
                    if (p_last) begin
                        m_data  <= result;
                        m_ovf   <= result_ovf;
                        m_valid <= 1'b1;
                        acc     <= '0;
                    end else begin
                        acc <= acc_next;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scoreboard bench for mac_accumulator (WIDTH=16, FRAC=15)
module tb_mac_accumulator;
    localparam int W = 16;

    typedef struct {
        logic signed [W-1:0] d;
        logic                o;
    } exp_t;

    logic clk = 1'b0;
    logic rst, clr, s_valid, s_ready, s_last, m_valid, m_ready, m_ovf;
    logic signed [W-1:0] s_a, s_b, m_data;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.WIDTH(W), .ACC_WIDTH(40), .FRAC(15)) dut (
        .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_ovf(m_ovf)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint sum);
        exp_t e;
        longint r;
        r = (sum + 16384) >>> 15;
        e.o = (r > 32767) || (r < -32768);
        e.d = r > 32767 ? 16'sh7fff : r < -32768 ? 16'sh8000 : W'(r);
        return e;
    endfunction

    task automatic push(input logic signed [W-1:0] d, input logic o);
        exp_t e;
        e.d = d;
        e.o = o;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input logic last);
        logic taken;
        taken = 1'b0;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        s_last = last;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = s_ready;
            cyc();
        end
        if (!taken) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed 0 expected 1");
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (sb.size() != 0 || m_valid); i++) cyc();
        chk("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed %0d expected none", m_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", m_data, e.d);
                chk("sb_ovf", m_ovf, e.o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e7;
        rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ovf", m_ovf, 0);
        chk("rst_s_ready", s_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle_s_ready", s_ready, 1);

        // single pair, latency and one-cycle valid
        push(8192, 0);
        s_valid = 1'b1; s_a = 16384; s_b = 16384; s_last = 1'b1;
        cyc();
        s_valid = 1'b0; s_last = 1'b0;
        chk("t1_lat_early", m_valid, 0);
        cyc();
        chk("t1_valid", m_valid, 1);
        chk("t1_data", m_data, 8192);
        cyc();
        chk("t1_valid_drop", m_valid, 0);

        // three full-scale products saturate
        push(32767, 1);
        send(32767, 32767, 0);
        send(32767, 32767, 0);
        send(32767, 32767, 1);
        drain();

        // negative rounding, then 2^30 saturation
        push(-32767, 0);
        send(-32768, 32767, 1);
        push(32767, 1);
        send(-32768, -32768, 1);
        drain();

        // backpressure on back-to-back frames
        m_ready = 1'b0;
        push(1, 0);
        push(2, 0);
        send(1, 32767, 1);
        send(2, 32767, 1);
        s_valid = 1'b1; s_a = 9; s_b = 9; s_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_s_ready", s_ready, 0);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, 1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b1;
        cyc();
        chk("bp_next_valid", m_valid, 1);
        chk("bp_next_data", m_data, 2);
        drain();

        // clr mid-frame: partial frame and the concurrent pair are discarded
        send(100, 100, 0);
        send(200, 200, 0);
        s_valid = 1'b1; s_a = 300; s_b = 300; s_last = 1'b0; clr = 1'b1;
        #1;
        chk("clr_s_ready", s_ready, 0);
        cyc();
        clr = 1'b0; s_valid = 1'b0;
        chk("clr_m_valid", m_valid, 0);
        push(1, 0);
        send(1, 32767, 1);
        drain();

        // clr drops a held result but keeps m_data
        m_ready = 1'b0;
        send(16384, 16384, 1);
        cyc();
        chk("clrh_valid", m_valid, 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clrh_valid_drop", m_valid, 0);
        chk("clrh_data_hold", m_data, 8192);
        m_ready = 1'b1;

        // mixed-sign multi-pair frame
        e7 = model(-1000 * 300 + 12345 * -2 + 7 * 7 + -20000 * -3);
        push(e7.d, e7.o);
        send(-1000, 300, 0);
        send(12345, -2, 0);
        send(7, 7, 0);
        send(-20000, -3, 1);
        drain();

        // async reset with a held result, then with a partial frame
        m_ready = 1'b0;
        send(-32768, -32768, 1);
        cyc();
        chk("ar_pre_valid", m_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_m_valid", m_valid, 0);
        chk("ar_m_data", m_data, 0);
        chk("ar_m_ovf", m_ovf, 0);
        chk("ar_s_ready", s_ready, 0);
        m_ready = 1'b1;
        cyc();
        rst = 1'b0;
        send(500, 500, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        push(8192, 0);
        send(16384, 16384, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
